// File: rtl/mem_access_stage.sv
// MEM pipeline stage: word-aligned data-memory access with wait-state stalling and timeout abandonment.
// Latency 1 cycle to MEM/WB regs on completion; stalls upstream while memory is not ready, up to TIMEOUT cycles.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic [31:0] ALUout_i,
  input  logic [31:0] ImmOp_i,
  input  logic [31:0] pcPlus4_i,
  input  logic [31:0] regOp2_i,
  input  logic        RegWrite_i,
  input  logic        MemWrite_i,
  input  logic [1:0]  WriteSrc_i,
  input  logic [4:0]  rd_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic        RegWrite_o,
  output logic [4:0]  rd_o,
  output logic [31:0] Result_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic        w_mem_op, w_misalign, w_access;
  logic        w_req, w_stall, w_complete, w_timeout, w_cnt_clr, w_cnt_inc;
  logic [31:0] w_result;
  logic        r_valid, r_regwrite, r_misalign, r_timeout;
  logic [4:0]  r_rd;
  logic [31:0] r_result;

  assign w_mem_op   = valid_i & (MemWrite_i | (WriteSrc_i == 2'b01));
  assign w_misalign = w_mem_op & (ALUout_i[1:0] != 2'b00);
  assign w_access   = w_mem_op & ~w_misalign;

  always_comb begin
    w_next     = r_state;
    w_req      = 1'b0;
    w_stall    = 1'b0;
    w_complete = 1'b0;
    w_timeout  = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_access) begin
          w_req = 1'b1;
          if (dmem_ready_i) begin
            w_complete = 1'b1;
          end else begin
            w_stall   = 1'b1;
            w_next    = WAIT;
            w_cnt_clr = 1'b1;
          end
        end else if (valid_i && !w_mem_op) begin
          w_complete = 1'b1;
        end
      end
      WAIT: begin
        // Ready wins over timeout when both land on the last permitted cycle.
        if (w_access) begin
          w_req = 1'b1;
          if (dmem_ready_i) begin
            w_complete = 1'b1;
            w_next     = IDLE;
          end else if (r_cnt == LP_LAST) begin
            w_req     = 1'b0;
            w_timeout = 1'b1;
            w_next    = IDLE;
          end else begin
            w_stall   = 1'b1;
            w_cnt_inc = 1'b1;
          end
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_result = ALUout_i;
    unique case (WriteSrc_i)
      2'b00: w_result = ALUout_i;
      2'b01: w_result = dmem_rdata_i;
      2'b10: w_result = pcPlus4_i;
      2'b11: w_result = ImmOp_i;
      default: w_result = ALUout_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd       <= 5'd0;
      r_result   <= 32'd0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_next;
      if (w_cnt_clr) r_cnt <= 8'd0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 8'd1;
      r_valid    <= w_complete;
      r_regwrite <= w_complete & RegWrite_i;
      if (w_complete) begin
        r_rd     <= rd_i;
        r_result <= w_result;
      end
      r_misalign <= w_misalign;
      r_timeout  <= w_timeout;
    end
  end

  // Gating with rst_ni drops the request immediately when reset hits mid-access.
  assign dmem_req_o   = w_req & rst_ni;
  assign stall_o      = w_stall & rst_ni;
  assign dmem_we_o    = w_req & rst_ni & MemWrite_i;
  assign dmem_addr_o  = ALUout_i;
  assign dmem_wdata_o = regOp2_i;
  assign valid_o      = r_valid;
  assign RegWrite_o   = r_regwrite;
  assign rd_o         = r_rd;
  assign Result_o     = r_result;
  assign misalign_o   = r_misalign;
  assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT=4; expected values are hand-computed constants.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] alu, imm, pc4, op2;
  logic        rw, mw;
  logic [1:0]  ws;
  logic [4:0]  rd;
  logic        req, we, ready, stall, valid_o, regwrite_o, misalign, tmo;
  logic [31:0] addr, wdata, rdata, result;
  logic [4:0]  rd_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i),
    .ALUout_i(alu), .ImmOp_i(imm), .pcPlus4_i(pc4), .regOp2_i(op2),
    .RegWrite_i(rw), .MemWrite_i(mw), .WriteSrc_i(ws), .rd_i(rd),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_wdata_o(wdata),
    .dmem_ready_i(ready), .dmem_rdata_i(rdata),
    .stall_o(stall), .valid_o(valid_o), .RegWrite_o(regwrite_o), .rd_o(rd_o),
    .Result_o(result), .misalign_o(misalign), .timeout_o(tmo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic set_op(input logic v, input logic [31:0] a, input logic [31:0] im,
                        input logic [31:0] p4, input logic [31:0] o2, input logic r,
                        input logic m, input logic [1:0] s, input logic [4:0] d);
    valid_i = v; alu = a; imm = im; pc4 = p4; op2 = o2;
    rw = r; mw = m; ws = s; rd = d;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b0; rdata = 32'd0;
    set_op(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 5'd0);
    #2;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // ALU op
    set_op(1'b1, 32'h10, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 5'd5);
    #4;
    chk("alu_stall", {31'd0, stall}, 32'd0);
    chk("alu_req", {31'd0, req}, 32'd0);
    step();
    chk("alu_valid", {31'd0, valid_o}, 32'd1);
    chk("alu_result", result, 32'h10);
    chk("alu_rd", {27'd0, rd_o}, 32'd5);
    chk("alu_rw", {31'd0, regwrite_o}, 32'd1);

    // pcPlus4 then immediate select, back to back
    set_op(1'b1, 32'h44, 32'h0, 32'h1004, 32'h0, 1'b1, 1'b0, 2'b10, 5'd1);
    step();
    chk("pc4_result", result, 32'h1004);
    set_op(1'b1, 32'h44, 32'hABCD, 32'h1004, 32'h0, 1'b0, 1'b0, 2'b11, 5'd2);
    step();
    chk("imm_result", result, 32'hABCD);
    chk("imm_rw", {31'd0, regwrite_o}, 32'd0);

    // Bubble
    set_op(1'b0, 32'h44, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 5'd3);
    #4;
    chk("bubble_req", {31'd0, req}, 32'd0);
    step();
    chk("bubble_valid", {31'd0, valid_o}, 32'd0);
    chk("bubble_rd_hold", {27'd0, rd_o}, 32'd2);

    // Load with 3 wait cycles
    set_op(1'b1, 32'h100, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 2'b01, 5'd7);
    ready = 1'b0;
    #4;
    chk("ld_c1_req", {31'd0, req}, 32'd1);
    chk("ld_c1_stall", {31'd0, stall}, 32'd1);
    chk("ld_c1_addr", addr, 32'h100);
    chk("ld_c1_we", {31'd0, we}, 32'd0);
    step();
    chk("ld_c1_bubble", {31'd0, valid_o}, 32'd0);
    #3;
    chk("ld_c2_stall", {31'd0, stall}, 32'd1);
    chk("ld_c2_req", {31'd0, req}, 32'd1);
    step();
    #3;
    chk("ld_c3_stall", {31'd0, stall}, 32'd1);
    chk("ld_c3_req", {31'd0, req}, 32'd1);
    step();
    ready = 1'b1; rdata = 32'hDEADBEEF;
    #3;
    chk("ld_c4_req", {31'd0, req}, 32'd1);
    chk("ld_c4_stall", {31'd0, stall}, 32'd0);
    step();
    chk("ld_valid", {31'd0, valid_o}, 32'd1);
    chk("ld_result", result, 32'hDEADBEEF);
    chk("ld_rd", {27'd0, rd_o}, 32'd7);

    // Zero-wait store
    set_op(1'b1, 32'h8, 32'h0, 32'h0, 32'hCAFE, 1'b0, 1'b1, 2'b00, 5'd4);
    ready = 1'b1;
    #4;
    chk("st_we", {31'd0, we}, 32'd1);
    chk("st_wdata", wdata, 32'hCAFE);
    chk("st_stall", {31'd0, stall}, 32'd0);
    step();
    chk("st_valid", {31'd0, valid_o}, 32'd1);
    chk("st_rw", {31'd0, regwrite_o}, 32'd0);
    chk("st_result", result, 32'h8);

    // Misaligned load
    set_op(1'b1, 32'h102, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 2'b01, 5'd6);
    ready = 1'b0;
    #4;
    chk("mis_req", {31'd0, req}, 32'd0);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    step();
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_valid", {31'd0, valid_o}, 32'd0);
    chk("mis_rw", {31'd0, regwrite_o}, 32'd0);
    set_op(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 5'd0);
    step();
    chk("mis_pulse_end", {31'd0, misalign}, 32'd0);

    // Timeout: 4 stall cycles then abandon
    set_op(1'b1, 32'h200, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 2'b01, 5'd8);
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #4;
      chk($sformatf("tmo_stall%0d", i), {31'd0, stall}, 32'd1);
      step();
    end
    #4;
    chk("tmo_cyc_stall", {31'd0, stall}, 32'd0);
    chk("tmo_cyc_req", {31'd0, req}, 32'd0);
    step();
    chk("tmo_pulse", {31'd0, timeout_o_or(tmo)}, 32'd1);
    chk("tmo_valid", {31'd0, valid_o}, 32'd0);
    chk("tmo_result_hold", result, 32'h8);
    set_op(1'b1, 32'h204, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 2'b01, 5'd9);
    ready = 1'b1; rdata = 32'h5555AAAA;
    #4;
    chk("tmo_idle_stall", {31'd0, stall}, 32'd0);
    step();
    chk("tmo_pulse_end", {31'd0, tmo}, 32'd0);
    chk("tmo_after_result", result, 32'h5555AAAA);

    // Reset during second cycle of a stalled load
    set_op(1'b1, 32'h300, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 2'b01, 5'd10);
    ready = 1'b0;
    step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, req}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_rd", {27'd0, rd_o}, 32'd0);
    step();
    rst_n = 1'b1;
    set_op(1'b1, 32'h0, 32'h1234, 32'h0, 32'h0, 1'b1, 1'b0, 2'b11, 5'd9);
    step();
    chk("post_rst_valid", {31'd0, valid_o}, 32'd1);
    chk("post_rst_result", result, 32'h1234);
    chk("post_rst_tmo", {31'd0, tmo}, 32'd0);
    set_op(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 5'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  function automatic logic timeout_o_or(input logic t);
    return t;
  endfunction

endmodule
